// File: rtl/cmp_seq_ctrl_if.sv
// Handshake/operand bundle between the hazard unit (master) and the
// multi-cycle branch comparator sequencer (slave).
interface cmp_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       cmp_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             cmp;

    modport master (
        output start, cmp_mode, a, b, flush,
        input  busy, done, cmp
    );

    modport slave (
        input  start, cmp_mode, a, b, flush,
        output busy, done, cmp
    );
endinterface

// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle sequencer for the ID-stage branch comparator.
// Latches operands on start, checks STEP mirrored bit pairs (i, WIDTH-1-i)
// per RUN cycle, then pulses done with the result on cmp.
// Mode encodings: 0 = EQUAL, 1 = NOTEQUAL, 2 = NOTEQUALZ (palindrome of a);
// any other encoding behaves as EQUAL.
// Optional feature macro: CMP_EARLY_EXIT_EN -- leave RUN on the first
// mismatching step instead of always running NSTEP cycles.
module cmp_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    cmp_seq_ctrl_if.slave bus
);
    localparam int NSTEP = WIDTH / (2 * STEP);
    localparam int CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] CMPMODE_EQUAL     = 4'd0;
    localparam logic [3:0] CMPMODE_NOTEQUAL  = 4'd1;
    localparam logic [3:0] CMPMODE_NOTEQUALZ = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic             acc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       mode_q;
    logic             busy_q;
    logic             done_q;
    logic             cmp_q;

    logic [STEP-1:0]  pair_ok;
    logic             acc_d;
    logic             cmp_d;
    logic             last_step;
    logic             finish_d;

    // One comparator slice per bit pair examined in the current step.
    for (genvar gi = 0; gi < STEP; gi++) begin : g_pair
        logic [IDXW-1:0] lo_idx;
        logic [IDXW-1:0] hi_idx;
        assign lo_idx = IDXW'(int'(cnt_q) * STEP + gi);
        assign hi_idx = IDXW'(WIDTH - 1) - lo_idx;
        assign pair_ok[gi] = (mode_q == CMPMODE_NOTEQUALZ)
                           ? (a_q[lo_idx] == a_q[hi_idx])
                           : ((a_q[lo_idx] == b_q[lo_idx]) && (a_q[hi_idx] == b_q[hi_idx]));
    end

    assign acc_d     = acc_q & (&pair_ok);
    assign cmp_d     = (mode_q == CMPMODE_NOTEQUAL) ? ~acc_d : acc_d;
    assign last_step = (cnt_q == CNTW'(NSTEP - 1));

`ifdef CMP_EARLY_EXIT_EN
    // Once acc has dropped the answer is known; stop stepping.
    assign finish_d = last_step | ~acc_d;
`else
    assign finish_d = last_step;
`endif

    // Sequencer FSM with registered busy/done/cmp outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= CMPMODE_EQUAL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // flush has nothing to abort here, so it is ignored.
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        mode_q  <= bus.cmp_mode;
                        cnt_q   <= '0;
                        acc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is not queued while running.
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNTW'(1);
                        if (finish_d) begin
                            cmp_q   <= cmp_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                    end else if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        mode_q  <= bus.cmp_mode;
                        cnt_q   <= '0;
                        acc_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.cmp  = cmp_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl: expected results are pushed to a
// scoreboard queue when an operation is started and popped when done pulses.
// Cycle 0 is the cycle in which start is driven; outputs are sampled on the
// falling edge, and inputs are changed right after sampling.
module tb_cmp_seq_ctrl;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int NSTEP = WIDTH / (2 * STEP);

    localparam logic [3:0] M_EQ  = 4'd0;
    localparam logic [3:0] M_NE  = 4'd1;
    localparam logic [3:0] M_NEZ = 4'd2;

    logic clk;
    logic reset;
    int   tests_run;
    int   fails;
    logic exp_q[$];

    cmp_seq_ctrl_if #(.WIDTH(WIDTH)) bif ();

    cmp_seq_ctrl #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic model_cmp(input logic [3:0] m, input logic [WIDTH-1:0] av,
                                       input logic [WIDTH-1:0] bv);
        case (m)
            M_NE:    return (av != bv);
            M_NEZ:   return (av == bitrev(av));
            default: return (av == bv);
        endcase
    endfunction

    // Cycle (relative to start) in which done is expected.
    function automatic int model_lat(input logic [3:0] m, input logic [WIDTH-1:0] av,
                                     input logic [WIDTH-1:0] bv);
`ifdef CMP_EARLY_EXIT_EN
        for (int s = 0; s < NSTEP; s++) begin
            for (int k = 0; k < STEP; k++) begin
                int i;
                i = s * STEP + k;
                if (m == M_NEZ) begin
                    if (av[i] != av[WIDTH-1-i]) return s + 2;
                end else begin
                    if (av[i] != bv[i] || av[WIDTH-1-i] != bv[WIDTH-1-i]) return s + 2;
                end
            end
        end
`endif
        return NSTEP + 1;
    endfunction

    task automatic drive_start(input logic [3:0] m, input logic [WIDTH-1:0] av,
                               input logic [WIDTH-1:0] bv);
        bif.start    = 1'b1;
        bif.cmp_mode = m;
        bif.a        = av;
        bif.b        = bv;
    endtask

    // One complete compare: checks busy each cycle, done latency and result.
    task automatic run_op(input string name, input logic [3:0] m,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int   lat;
        bit   got;
        logic e;
        lat = model_lat(m, av, bv);
        got = 1'b0;
        @(negedge clk);
        drive_start(m, av, bv);
        exp_q.push_back(model_cmp(m, av, bv));
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (c == 1) bif.start = 1'b0;
            tests_run++;
            if (bif.busy !== (c < lat)) begin
                fails++;
                $display("FAIL %s busy c%0d: got %b want %b", name, c, bif.busy, (c < lat));
            end
            if (bif.done === 1'b1) begin
                got = 1'b1;
                e = exp_q.pop_front();
                tests_run++;
                if (c != lat) begin
                    fails++;
                    $display("FAIL %s latency: got %0d want %0d", name, c, lat);
                end
                tests_run++;
                if (bif.cmp !== e) begin
                    fails++;
                    $display("FAIL %s cmp: got %b want %b", name, bif.cmp, e);
                end
                $display("[TB] %s mode=%0d a=%h b=%h cmp=%b lat=%0d", name, m, av, bv, bif.cmp, c);
            end
        end
        if (!got) begin
            tests_run++;
            fails++;
            $display("FAIL %s timeout: got no done want done", name);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.start = 1'b0; bif.flush = 1'b0; bif.cmp_mode = M_EQ; bif.a = '0; bif.b = '0;
        repeat (3) @(negedge clk);
        tests_run += 3;
        if (bif.busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", bif.busy); end
        if (bif.done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", bif.done); end
        if (bif.cmp  !== 1'b0) begin fails++; $display("FAIL reset cmp: got %b want 0", bif.cmp); end
        $display("[TB] reset busy=%b done=%b cmp=%b", bif.busy, bif.done, bif.cmp);
        reset = 1'b0;
    endtask

    task automatic test_modes();
        logic [WIDTH-1:0] av, bv;
        logic [3:0]       m;
        run_op("nez_pal",  M_NEZ, 32'h8000_0001, 32'h0);
        run_op("eq_same",  M_EQ,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("ne_same",  M_NE,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("nez_nopal", M_NEZ, 32'h0000_0002, 32'h0);
        run_op("ne_diff",  M_NE,  32'h1234_5678, 32'h1234_5679);
        run_op("unk_mode", 4'hF,  32'hCAFE_F00D, 32'hCAFE_F00D);
        for (int n = 0; n < 10; n++) begin
            m  = 4'($urandom_range(0, 2));
            av = $urandom;
            bv = ($urandom_range(0, 1) == 0) ? av : (av ^ (32'h1 << $urandom_range(0, 31)));
            if (m == M_NEZ && $urandom_range(0, 1) == 0) av = {av[31:16], bitrev(av)[31:16]};
            run_op("rand", m, av, bv);
        end
    endtask

    task automatic test_early_exit();
        run_op("eq_mis_step0", M_EQ, 32'h0000_0001, 32'h0);
        run_op("eq_mis_step3", M_EQ, 32'h0001_0000, 32'h0);
    endtask

    task automatic test_flush();
        int n_done;
        logic e;
        run_op("pre_flush", M_EQ, 32'h5555_AAAA, 32'h5555_AAAA);
        n_done = 0;
        @(negedge clk);
        drive_start(M_EQ, 32'h0001_0000, 32'h0);   // would give cmp=0 if not flushed
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bif.done === 1'b1) begin
                n_done++;
                tests_run++;
                if (c != 9) begin fails++; $display("FAIL flush done cycle: got %0d want 9", c); end
                e = exp_q.pop_front();
                tests_run++;
                if (bif.cmp !== e) begin fails++; $display("FAIL flush restart cmp: got %b want %b", bif.cmp, e); end
            end
            if (c == 3 || c == 4) begin
                tests_run += 2;
                if (bif.busy !== 1'b0) begin fails++; $display("FAIL flush busy c%0d: got %b want 0", c, bif.busy); end
                if (bif.cmp !== 1'b1) begin fails++; $display("FAIL flush cmp hold c%0d: got %b want 1", c, bif.cmp); end
            end
            case (c)
                1: bif.start = 1'b0;
                2: bif.flush = 1'b1;
                3: bif.flush = 1'b0;
                4: begin
                    drive_start(M_NEZ, 32'h8000_0001, 32'h0);
                    exp_q.push_back(1'b1);
                end
                5: bif.start = 1'b0;
                default: ;
            endcase
        end
        tests_run++;
        if (n_done != 1) begin fails++; $display("FAIL flush done count: got %0d want 1", n_done); end
        $display("[TB] flush dones=%0d cmp=%b", n_done, bif.cmp);
        // flush together with start in IDLE must not block the start.
        @(negedge clk);
        drive_start(M_EQ, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
        bif.flush = 1'b1;
        @(negedge clk);
        bif.start = 1'b0; bif.flush = 1'b0;
        tests_run++;
        if (bif.busy !== 1'b1) begin fails++; $display("FAIL idle_flush busy: got %b want 1", bif.busy); end
        n_done = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (bif.done === 1'b1) begin
                n_done++;
                tests_run++;
                if (c != 5) begin fails++; $display("FAIL idle_flush done cycle: got %0d want 5", c); end
            end
        end
        tests_run++;
        if (n_done != 1) begin fails++; $display("FAIL idle_flush done count: got %0d want 1", n_done); end
        $display("[TB] idle flush+start dones=%0d", n_done);
    endtask

    task automatic test_back_to_back();
        int n_done;
        int want_c[$];
        logic e;
        // Start pulse during RUN, plus operand change, must be ignored.
        n_done = 0;
        @(negedge clk);
        drive_start(M_EQ, 32'h1357_9BDF, 32'h1357_9BDF);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bif.done === 1'b1) begin
                n_done++;
                e = exp_q.pop_front();
                tests_run += 2;
                if (c != 5) begin fails++; $display("FAIL ignore_start done cycle: got %0d want 5", c); end
                if (bif.cmp !== e) begin fails++; $display("FAIL ignore_start cmp: got %b want %b", bif.cmp, e); end
            end
            if (c == 1) bif.start = 1'b0;
            if (c == 2) begin bif.start = 1'b1; bif.a = 32'hFFFF_0000; end
            if (c == 3) bif.start = 1'b0;
        end
        tests_run++;
        if (n_done != 1) begin fails++; $display("FAIL ignore_start done count: got %0d want 1", n_done); end
        $display("[TB] ignored start dones=%0d", n_done);
        // Start held through DONE: second op chains straight into RUN.
        n_done = 0;
        want_c = '{5, 10};
        @(negedge clk);
        drive_start(M_EQ, 32'h2468_ACE0, 32'h2468_ACE0);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bif.done === 1'b1) begin
                e = exp_q.pop_front();
                tests_run += 2;
                if (n_done >= 2 || c != want_c[n_done]) begin
                    fails++; $display("FAIL b2b done cycle: got %0d (done #%0d)", c, n_done);
                end
                if (bif.cmp !== e) begin fails++; $display("FAIL b2b cmp #%0d: got %b want %b", n_done, bif.cmp, e); end
                n_done++;
            end
            if (c == 6) begin
                tests_run++;
                if (bif.busy !== 1'b1) begin fails++; $display("FAIL b2b busy c6: got %b want 1", bif.busy); end
            end
            if (c == 1) begin
                bif.cmp_mode = M_NE; bif.a = 32'h0BAD_F00D; bif.b = 32'h0BAD_F00D;
                exp_q.push_back(1'b0);
            end
            if (c == 6) bif.start = 1'b0;
        end
        tests_run++;
        if (n_done != 2) begin fails++; $display("FAIL b2b done count: got %0d want 2", n_done); end
        $display("[TB] back-to-back dones=%0d", n_done);
    endtask

    task automatic test_reset_mid();
        int n_done;
        run_op("pre_reset", M_EQ, 32'h7777_7777, 32'h7777_7777);
        n_done = 0;
        @(negedge clk);
        drive_start(M_EQ, 32'h3C3C_3C3C, 32'h3C3C_3C3C);
        exp_q.push_back(1'b1);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 4) begin
                tests_run += 3;
                if (bif.busy !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b want 0", bif.busy); end
                if (bif.done !== 1'b0) begin fails++; $display("FAIL midreset done: got %b want 0", bif.done); end
                if (bif.cmp  !== 1'b0) begin fails++; $display("FAIL midreset cmp: got %b want 0", bif.cmp); end
            end
            if (c > 4 && bif.done === 1'b1) n_done++;
            if (c == 1) bif.start = 1'b0;
            if (c == 3) begin reset = 1'b1; exp_q.delete(); end
            if (c == 4) reset = 1'b0;
        end
        tests_run++;
        if (n_done != 0) begin fails++; $display("FAIL midreset stray done: got %0d want 0", n_done); end
        $display("[TB] mid-op reset busy=%b cmp=%b stray_dones=%0d", bif.busy, bif.cmp, n_done);
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_modes();
        test_early_exit();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
